fifo_read_packer: RTL

- Read-domain consumer of the async FIFO's read port.
- Pops DATA_WIDTH words whenever the FIFO is non-empty and the block has room, and packs PACK_RATIO consecutive words into one wide word.
- Presents each wide word on a valid/ready master stream; flush_in forces out a partial word.
- Runs entirely on the FIFO's read clock; sits between the FIFO read port and the downstream read-domain datapath.

---
 rtl/fifo_pack_pkg.sv | 38 +++
 rtl/pack_output_reg.sv | 47 ++++
 rtl/fifo_read_packer.sv | 106 ++++++++++
 3 files changed

// File: rtl/fifo_pack_pkg.sv
// Shared types and helpers for the FIFO read-side word packer.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package fifo_pack_pkg;

  // Assembly side: collecting lanes, or holding a finished word for the output register.
  typedef enum logic {
    ASM_FILL,
    ASM_READY
  } asm_state_t;

  // Output register side of the valid/ready stream.
  typedef enum logic {
    OUT_IDLE,
    OUT_VALID
  } out_state_t;

  // Widest lane concatenation the helper handles (DATA_WIDTH*PACK_RATIO must fit).
  localparam int unsigned LANE_BITS_MAX = 512;

  // Keep the first count*lane_w bits of the lane concatenation and zero the
  // rest, so unused upper lanes of a partial word always read as 0.
  function automatic logic [LANE_BITS_MAX-1:0] lanes_to_bits(
    input logic [LANE_BITS_MAX-1:0] lanes,
    input int unsigned              count,
    input int unsigned              lane_w
  );
    logic [LANE_BITS_MAX-1:0] bits;
    bits = '0;
    for (int unsigned b = 0; b < LANE_BITS_MAX; b++) begin
      if (b < count * lane_w) begin
        bits[b] = lanes[b];
      end
    end
    return bits;
  endfunction

endpackage

// File: rtl/pack_output_reg.sv
// Valid/ready output register holding one packed word and its lane count.
// Latency: load at an edge -> valid_o high the following cycle.
// Backpressure: accept_o low while a word is held and m_ready_i is low; data is held stable.
module pack_output_reg
  import fifo_pack_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_dat_i,
  input  logic [CNT_W-1:0]  load_cnt_i,
  input  logic              m_ready_i,
  output logic              accept_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] dat_o,
  output logic [CNT_W-1:0]  cnt_o
);

  out_state_t        state_q;
  logic [DATA_W-1:0] dat_q;
  logic [CNT_W-1:0]  cnt_q;

  // Room for a new word when empty, or when the held word leaves this edge.
  assign accept_o = (state_q == OUT_IDLE) || m_ready_i;
  assign valid_o  = (state_q == OUT_VALID);
  assign dat_o    = dat_q;
  assign cnt_o    = cnt_q;

  // Output FSM: load takes priority; otherwise a handshake empties the register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= OUT_IDLE;
      dat_q   <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      state_q <= OUT_VALID;
      dat_q   <= load_dat_i;
      cnt_q   <= load_cnt_i;
    end else if ((state_q == OUT_VALID) && m_ready_i) begin
      state_q <= OUT_IDLE;
    end
  end

endmodule

// File: rtl/fifo_read_packer.sv
// Pops FIFO words and packs PACK_RATIO of them (or fewer on flush) into one wide stream word.
// Latency: 1 cycle from the completing pop/flush edge to m_valid_out when the output register is free.
// Backpressure: a finished word waits in ASM_READY and pops stop until the output register accepts it.
module fifo_read_packer
  import fifo_pack_pkg::*;
#(
  parameter  int DATA_WIDTH = 4,
  parameter  int PACK_RATIO = 2,
  localparam int CNT_WIDTH  = $clog2(PACK_RATIO + 1)
) (
  input  logic                           r_clk_in,
  input  logic                           r_reset_in,
  input  logic                           fifo_empty_in,
  input  logic [DATA_WIDTH-1:0]          fifo_data_in,
  output logic                           fifo_request_out,
  input  logic                           flush_in,
  input  logic                           m_ready_in,
  output logic                           m_valid_out,
  output logic [DATA_WIDTH*PACK_RATIO-1:0] m_data_out,
  output logic [CNT_WIDTH-1:0]           m_count_out,
  output logic                           busy_out
);

  localparam int OUT_W = DATA_WIDTH * PACK_RATIO;
  localparam logic [CNT_WIDTH-1:0] FULL_CNT = CNT_WIDTH'(PACK_RATIO);

  asm_state_t                              asm_q;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]   lanes_q;
  logic [CNT_WIDTH-1:0]                    lane_cnt_q;
  logic                                    flush_pending_q;

  logic                                    pop;
  logic [PACK_RATIO-1:0][DATA_WIDTH-1:0]   lanes_d;
  logic [CNT_WIDTH-1:0]                    lane_cnt_d;
  logic                                    flush_eff;
  logic                                    complete;
  logic                                    load_req;
  logic                                    out_accept;
  logic                                    load;
  logic [OUT_W-1:0]                        load_dat;

  // Pop decision, lane write and completion detection for this edge.
  always_comb begin
    pop = !r_reset_in && !fifo_empty_in && (asm_q == ASM_FILL) && !flush_pending_q;

    lanes_d = lanes_q;
    for (int i = 0; i < PACK_RATIO; i++) begin
      if (pop && (lane_cnt_q == CNT_WIDTH'(i))) begin
        lanes_d[i] = fifo_data_in;
      end
    end
    lane_cnt_d = lane_cnt_q + CNT_WIDTH'(pop);

    // A flush only matters once at least one lane (including this edge's pop) is held.
    flush_eff = flush_pending_q || flush_in;
    complete  = (lane_cnt_d == FULL_CNT) || (flush_eff && (lane_cnt_d != '0));

    // In ASM_READY the word is already complete and simply waits for room.
    load_req = (asm_q == ASM_READY) || complete;
    load     = load_req && out_accept;

    load_dat = OUT_W'(lanes_to_bits(LANE_BITS_MAX'(lanes_d), 32'(lane_cnt_d), DATA_WIDTH));
  end

  assign fifo_request_out = pop;
  assign busy_out         = (lane_cnt_q != '0) || flush_pending_q;

  // Assembly FSM: transfer clears the lanes, otherwise accumulate and park a finished word.
  always_ff @(posedge r_clk_in) begin
    if (r_reset_in) begin
      asm_q           <= ASM_FILL;
      lanes_q         <= '0;
      lane_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else if (load) begin
      asm_q           <= ASM_FILL;
      lanes_q         <= '0;
      lane_cnt_q      <= '0;
      flush_pending_q <= 1'b0;
    end else begin
      lanes_q         <= lanes_d;
      lane_cnt_q      <= lane_cnt_d;
      flush_pending_q <= flush_eff && (lane_cnt_d != '0);
      if ((asm_q == ASM_FILL) && complete) begin
        asm_q <= ASM_READY;
      end
    end
  end

  pack_output_reg #(
    .DATA_W (OUT_W),
    .CNT_W  (CNT_WIDTH)
  ) u_out (
    .clk_i      (r_clk_in),
    .rst_i      (r_reset_in),
    .load_i     (load),
    .load_dat_i (load_dat),
    .load_cnt_i (lane_cnt_d),
    .m_ready_i  (m_ready_in),
    .accept_o   (out_accept),
    .valid_o    (m_valid_out),
    .dat_o      (m_data_out),
    .cnt_o      (m_count_out)
  );

endmodule
